// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, debug and memory-side signals of the shared memory arbiter.
interface mem_arbiter_if #(parameter int AW = 5, parameter int DW = 8);
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall, cpu_halt;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_halt,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall, dbg_rdata, dbg_ack,
    output mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_halt,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall, dbg_rdata, dbg_ack,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the program/data memory between CPU and debug port.
// Define ARB_CPU_PRIO_EN for fixed priority where an eligible CPU always wins.
module mem_arbiter #(parameter int AW = 5, parameter int DW = 8) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state;
  logic owner, we, dn, ce, de, go, sel, we_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n, cpu_q, dbg_q, rd;
`ifndef ARB_CPU_PRIO_EN
  logic last;
`endif
  always_comb begin
    dn = state == DONE;
    ce = bus.cpu_req & ~bus.cpu_halt & ~(dn & ~owner);
`ifdef ARB_CPU_PRIO_EN
    de = bus.dbg_req & ~(dn & owner) & ~(bus.cpu_req & ~bus.cpu_halt);
    sel = ~ce;
`else
    de = bus.dbg_req & ~(dn & owner);
    sel = ce & de ? ~last : de;
`endif
    go = (state != ACC) & (ce | de);
    we_n = sel ? bus.dbg_we : bus.cpu_we;
    addr_n = sel ? bus.dbg_addr : bus.cpu_addr;
    wdata_n = sel ? bus.dbg_wdata : bus.cpu_wdata;
    rd = we ? '0 : bus.mem_rdata;
    bus.cpu_stall = ce;
    bus.cpu_rdata = bus.cpu_ack ? rd : cpu_q;
    bus.dbg_rdata = bus.dbg_ack ? rd : dbg_q;
  end
  // owner: 0 = CPU, 1 = debug; DONE doubles as the arbitration slot for the next access
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
`ifndef ARB_CPU_PRIO_EN
      last <= 1'b1;
`endif
      we <= 1'b0;
      cpu_q <= '0;
      dbg_q <= '0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      if (dn & ~owner) cpu_q <= rd;
      if (dn & owner) dbg_q <= rd;
      if (state == ACC) begin
        state <= DONE;
        bus.cpu_ack <= ~owner;
        bus.dbg_ack <= owner;
      end else if (go) begin
        state <= ACC;
        owner <= sel;
`ifndef ARB_CPU_PRIO_EN
        last <= sel;
`endif
        we <= we_n;
        bus.mem_addr <= addr_n;
        bus.mem_wdata <= wdata_n;
        bus.mem_read <= ~we_n;
        bus.mem_write <= we_n;
      end else state <= IDLE;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and sequence checks of mem_arbiter with a read-data scoreboard.
module tb_mem_arbiter;
  typedef struct {
    bit         d;
    bit         we;
    logic [4:0] a;
    logic [7:0] w;
    logic [7:0] r;
  } vec_t;
  logic clk = 0, rst = 1;
  int n = 0, m = 0;
  bit sb_on = 1, seeded = 0;
  logic [7:0] mem [32];
  logic [7:0] cq[$], dq[$];
  logic [7:0] lc = 0, ld = 0;
  vec_t v[8];
  mem_arbiter_if #(.AW(5), .DW(8)) bus();
  mem_arbiter #(.AW(5), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!seeded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 1);
      mem[5] <= 8'hA7;
      seeded <= 1;
    end else begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr];
    end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n++;
    if (a !== e) begin
      m++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bus.mem_read | bus.mem_write) chk("single strobe", {31'b0, bus.mem_read ^ bus.mem_write}, 1);
      if (sb_on && bus.cpu_ack) begin
        if (cq.size() == 0) chk("cpu unexpected ack", 1, 0);
        else chk("cpu rdata", bus.cpu_rdata, cq.pop_front());
      end
      if (sb_on && bus.dbg_ack) begin
        if (dq.size() == 0) chk("dbg unexpected ack", 1, 0);
        else chk("dbg rdata", bus.dbg_rdata, dq.pop_front());
      end
    end
  task automatic do_reset();
    rst = 1;
    {bus.cpu_req, bus.cpu_we, bus.cpu_halt, bus.dbg_req, bus.dbg_we} = '0;
    {bus.cpu_addr, bus.dbg_addr, bus.cpu_wdata, bus.dbg_wdata} = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    lc = 0;
    ld = 0;
  endtask
  task automatic run(input vec_t x);
    @(posedge clk);
    #1;
    if (x.d) begin
      bus.dbg_req = 1; bus.dbg_we = x.we; bus.dbg_addr = x.a; bus.dbg_wdata = x.w; dq.push_back(x.r);
    end else begin
      bus.cpu_req = 1; bus.cpu_we = x.we; bus.cpu_addr = x.a; bus.cpu_wdata = x.w; cq.push_back(x.r);
    end
    @(negedge clk);
    chk("stall idle", bus.cpu_stall, !x.d);
    chk("no strobe idle", {bus.mem_read, bus.mem_write}, 0);
    @(negedge clk);
    chk("read strobe", bus.mem_read, !x.we);
    chk("write strobe", bus.mem_write, x.we);
    chk("mem addr", bus.mem_addr, x.a);
    if (x.we) chk("mem wdata", bus.mem_wdata, x.w);
    chk("stall acc", bus.cpu_stall, !x.d);
    @(negedge clk);
    chk("owner ack", x.d ? bus.dbg_ack : bus.cpu_ack, 1);
    chk("other ack", x.d ? bus.cpu_ack : bus.dbg_ack, 0);
    chk("stall done", bus.cpu_stall, 0);
    chk("no strobe done", {bus.mem_read, bus.mem_write}, 0);
    if (x.d) begin bus.dbg_req = 0; ld = x.r; end
    else begin bus.cpu_req = 0; lc = x.r; end
    @(negedge clk);
    chk("cpu rdata hold", bus.cpu_rdata, lc);
    chk("dbg rdata hold", bus.dbg_rdata, ld);
    chk("acks low after", {bus.cpu_ack, bus.dbg_ack}, 0);
  endtask
  initial begin
    int ca, da, nc, nd;
    bit ec, ed;
    v[0] = '{1'b0, 1'b0, 5'd5,  8'h00, 8'hA7};
    v[1] = '{1'b1, 1'b1, 5'd3,  8'h3C, 8'h00};
    v[2] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'h3C};
    v[3] = '{1'b0, 1'b1, 5'd31, 8'h55, 8'h00};
    v[4] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'h55};
    v[5] = '{1'b0, 1'b1, 5'd0,  8'hFF, 8'h00};
    v[6] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'hFF};
    v[7] = '{1'b1, 1'b0, 5'd5,  8'h00, 8'hA7};
    do_reset();
    @(negedge clk);
    chk("reset acks", {bus.cpu_ack, bus.dbg_ack}, 0);
    chk("reset strobes", {bus.mem_read, bus.mem_write}, 0);
    chk("reset stall", bus.cpu_stall, 0);
    chk("reset mem addr", bus.mem_addr, 0);
    chk("reset rdata", {bus.cpu_rdata, bus.dbg_rdata}, 0);
    foreach (v[i]) run(v[i]);
    // simultaneous requests straight out of reset
    do_reset();
    bus.cpu_req = 1; bus.cpu_addr = 5; cq.push_back(8'hA7);
    bus.dbg_req = 1; bus.dbg_addr = 3; dq.push_back(8'h3C);
    ca = 0; da = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin ca = c; bus.cpu_req = 0; end
      if (bus.dbg_ack) begin da = c; bus.dbg_req = 0; end
    end
    chk("tie cpu ack cycle", ca, 3);
    chk("tie dbg ack cycle", da, 5);
    // continuous requests from both ports
    do_reset();
    sb_on = 0;
    bus.cpu_req = 1; bus.cpu_addr = 5;
    bus.dbg_req = 1; bus.dbg_addr = 3;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
`ifdef ARB_CPU_PRIO_EN
      ec = c >= 3 && c % 3 == 0;
      ed = 0;
`else
      ec = c >= 3 && c % 4 == 3;
      ed = c >= 5 && c % 4 == 1;
`endif
      chk("stream cpu ack", bus.cpu_ack, ec);
      chk("stream dbg ack", bus.dbg_ack, ed);
      if (bus.cpu_ack) chk("stream cpu rdata", bus.cpu_rdata, 8'hA7);
      if (bus.dbg_ack) chk("stream dbg rdata", bus.dbg_rdata, 8'h3C);
    end
    bus.cpu_req = 0; bus.dbg_req = 0;
    repeat (4) @(negedge clk);
    sb_on = 1;
    // halted CPU is never served
    do_reset();
    bus.cpu_halt = 1; bus.cpu_req = 1; bus.cpu_addr = 5;
    bus.dbg_req = 1; bus.dbg_addr = 3; dq.push_back(8'h3C);
    nc = 0; nd = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("halt stall", bus.cpu_stall, 0);
      if (bus.cpu_ack) nc++;
      if (bus.dbg_ack) begin nd++; bus.dbg_req = 0; end
    end
    chk("halt cpu acks", nc, 0);
    chk("halt dbg acks", nd, 1);
    bus.cpu_req = 0; bus.cpu_halt = 0;
    // halt rising during a CPU access lets it finish
    @(posedge clk);
    #1 bus.cpu_req = 1; bus.cpu_addr = 5; cq.push_back(8'hA7);
    ca = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) bus.cpu_halt = 1;
      if (bus.cpu_ack) begin ca = c; bus.cpu_req = 0; end
    end
    chk("halt mid access ack", ca, 3);
    bus.cpu_halt = 0;
    // reset in the middle of a write
    do_reset();
    @(posedge clk);
    #1 bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 7; bus.dbg_wdata = 8'h99;
    repeat (2) @(negedge clk);
    chk("write issued", bus.mem_write, 1);
    #1 rst = 1; bus.dbg_req = 0;
    #1;
    chk("async clear strobes", {bus.mem_read, bus.mem_write}, 0);
    chk("async clear acks", {bus.cpu_ack, bus.dbg_ack}, 0);
    chk("async clear addr", bus.mem_addr, 0);
    @(posedge clk);
    #1 rst = 0;
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.dbg_ack) nd++;
    end
    chk("no ack after reset", nd, 0);
    chk("aborted write dropped", mem[7], 8'h32);
    bus.dbg_we = 0;
    run(v[0]);
    chk("scoreboard drained", cq.size() + dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, m);
    $finish;
  end
endmodule
